// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 key decoder.
package ps2_key_decoder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StOut
  } state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] ERR_00    = 8'h00;
  localparam logic [7:0] ERR_FF    = 8'hFF;

endpackage

// File: rtl/ps2_key_decoder_scancode_ascii.sv
// Combinational set-2 scan code to ASCII lookup with shift applied.
module scancode_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic [7:0] alt;

  always_comb begin
    base = 8'h00;
    alt  = 8'h00;
    case (code)
      8'h1C: base = "a";
      8'h32: base = "b";
      8'h21: base = "c";
      8'h23: base = "d";
      8'h24: base = "e";
      8'h2B: base = "f";
      8'h34: base = "g";
      8'h33: base = "h";
      8'h43: base = "i";
      8'h3B: base = "j";
      8'h42: base = "k";
      8'h4B: base = "l";
      8'h3A: base = "m";
      8'h31: base = "n";
      8'h44: base = "o";
      8'h4D: base = "p";
      8'h15: base = "q";
      8'h2D: base = "r";
      8'h1B: base = "s";
      8'h2C: base = "t";
      8'h3C: base = "u";
      8'h2A: base = "v";
      8'h1D: base = "w";
      8'h22: base = "x";
      8'h35: base = "y";
      8'h1A: base = "z";
      8'h45: begin base = "0"; alt = ")"; end
      8'h16: begin base = "1"; alt = "!"; end
      8'h1E: begin base = "2"; alt = "@"; end
      8'h26: begin base = "3"; alt = "#"; end
      8'h25: begin base = "4"; alt = "$"; end
      8'h2E: begin base = "5"; alt = "%"; end
      8'h36: begin base = "6"; alt = "^"; end
      8'h3D: begin base = "7"; alt = "&"; end
      8'h3E: begin base = "8"; alt = "*"; end
      8'h46: begin base = "9"; alt = "("; end
      8'h41: begin base = ","; alt = "<"; end
      8'h49: begin base = "."; alt = ">"; end
      8'h4A: begin base = "/"; alt = "?"; end
      8'h4C: begin base = ";"; alt = ":"; end
      8'h4E: begin base = "-"; alt = "_"; end
      8'h55: begin base = "="; alt = "+"; end
      8'h29: base = " ";
      8'h5A: base = 8'h0D;
      default: ;
    endcase
    if (base >= "a" && base <= "z") alt = base - 8'h20;
    // Keys without a shifted form (space, enter) keep their base character.
    ascii = (shift && alt != 8'h00) ? alt : base;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to key events: prefix handling, held-key repeat filter,
// shift tracking and ASCII translation, with a ready/valid event output.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned REPEAT_EN = 0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic [7:0] key_cnt,
  output logic       shift,
  output logic       err
);

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d, ascii_q, ascii_d, cnt_q, cnt_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d, err_q, err_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d, held_vld_q, held_vld_d;

  logic       is_ext, is_brk, held_hit;
  logic [7:0] lut_ascii;

  assign is_ext   = (state_q == StExt) || (state_q == StExtBrk);
  assign is_brk   = (state_q == StBrk) || (state_q == StExtBrk);
  assign held_hit = held_vld_q && (held_code_q == in_data) && (held_ext_q == is_ext);
  assign in_ready = (state_q != StOut);

  scancode_ascii u_scancode_ascii (
    .code  (in_data),
    .shift (lshift_q | rshift_q),
    .ascii (lut_ascii)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ascii_d     = ascii_q;
    cnt_d       = cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    err_d       = err_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    held_vld_d  = held_vld_q;

    if (state_q == StOut) begin
      if (ev_ready) state_d = StIdle;
    end else if (in_valid) begin
      case (in_data)
        PFX_EXT: state_d = StExt;
        PFX_BRK: begin
          if (state_q == StIdle)     state_d = StBrk;
          else if (state_q == StExt) state_d = StExtBrk;
        end
        PFX_PAUSE: state_d = state_q;
        ERR_00, ERR_FF: begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
        default: begin
          if (!is_brk && held_hit && REPEAT_EN == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StOut;
            code_d  = in_data;
            ext_d   = is_ext;
            brk_d   = is_brk;
            // Uses shift as it was before this event, so a shift key reports 0.
            ascii_d = is_ext ? 8'h00 : lut_ascii;
            if (!is_brk) begin
              cnt_d       = cnt_q + 8'd1;
              held_code_d = in_data;
              held_ext_d  = is_ext;
              held_vld_d  = 1'b1;
            end else if (held_hit) begin
              held_vld_d = 1'b0;
            end
            if (!is_ext && in_data == SC_LSHIFT) lshift_d = !is_brk;
            if (!is_ext && in_data == SC_RSHIFT) rshift_d = !is_brk;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= StIdle;
      code_q      <= 8'h00;
      ascii_q     <= 8'h00;
      cnt_q       <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      err_q       <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      held_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ascii_q     <= ascii_d;
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      err_q       <= err_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      held_vld_q  <= held_vld_d;
    end
  end

  assign ev_valid = (state_q == StOut);
  assign ev_code  = code_q;
  assign ev_ext   = ext_q;
  assign ev_break = brk_q;
  assign ev_ascii = ascii_q;
  assign key_cnt  = cnt_q;
  assign shift    = lshift_q | rshift_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: byte-level behavioural model checked every cycle,
// directed scenarios with literal expectations, and randomized byte streams.
module tb_ps2_key_decoder;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] in_data;
  logic       in_valid, in_ready, ev_valid, ev_ready, ev_ext, ev_break, shift, err;
  logic [7:0] ev_code, ev_ascii, key_cnt;

  logic [7:0] in_data1;
  logic       in_valid1, in_ready1, ev_valid1, ev_ext1, ev_break1, shift1, err1;
  logic       ev_ready1 = 1'b1;
  logic [7:0] ev_code1, ev_ascii1, key_cnt1;

  int total = 0;
  int bad   = 0;
  int rdy_mode;
  int ev1_n;

  always #5 clk = ~clk;

  ps2_key_decoder #(.REPEAT_EN(0)) dut (
    .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_ascii(ev_ascii), .key_cnt(key_cnt), .shift(shift), .err(err)
  );

  ps2_key_decoder #(.REPEAT_EN(1)) dut_rep (
    .clk(clk), .clrn(clrn), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .ev_valid(ev_valid1), .ev_ready(ev_ready1), .ev_code(ev_code1), .ev_ext(ev_ext1),
    .ev_break(ev_break1), .ev_ascii(ev_ascii1), .key_cnt(key_cnt1), .shift(shift1), .err(err1)
  );

  // ---------------- reference model ----------------
  logic [7:0] lo_tab [256];
  logic [7:0] hi_tab [256];
  logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                          8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                          8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pc [6]  = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h4E, 8'h55};
  logic [7:0] pool [8] = '{8'h1C, 8'h32, 8'h16, 8'h29, 8'h5A, 8'h41, 8'h75, 8'h4E};

  ev_t        exp_q[$];
  ev_t        ev_log[$];
  logic       m_x, m_b, m_lsh, m_rsh, m_err, m_hvld, m_hext;
  logic [7:0] m_hcode, m_cnt;

  initial begin
    string ds, pl, ph;
    ds = ")!@#$%^&*(";
    pl = ",./;-=";
    ph = "<>?:_+";
    for (int i = 0; i < 256; i++) begin
      lo_tab[i] = 8'h00;
      hi_tab[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) begin
      lo_tab[lc[i]] = 8'(97 + i);
      hi_tab[lc[i]] = 8'(65 + i);
    end
    for (int i = 0; i < 10; i++) begin
      lo_tab[dc[i]] = 8'(48 + i);
      hi_tab[dc[i]] = ds[i];
    end
    for (int i = 0; i < 6; i++) begin
      lo_tab[pc[i]] = pl[i];
      hi_tab[pc[i]] = ph[i];
    end
    lo_tab[8'h29] = 8'h20; hi_tab[8'h29] = 8'h20;
    lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D;
  end

  task automatic m_reset();
    m_x = 0; m_b = 0; m_lsh = 0; m_rsh = 0; m_err = 0; m_hvld = 0; m_hext = 0;
    m_hcode = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // One accepted byte; REPEAT_EN=0 semantics.
  task automatic m_byte(input logic [7:0] b);
    ev_t  e;
    logic make, same;
    if (b == 8'hE0) begin
      m_x = 1; m_b = 0;
    end else if (b == 8'hF0) begin
      m_b = 1;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1; m_x = 0; m_b = 0;
    end else if (b != 8'hE1) begin
      make = !m_b;
      same = m_hvld && m_hcode == b && m_hext == m_x;
      if (!(make && same)) begin
        e.code  = b;
        e.ext   = m_x;
        e.brk   = m_b;
        e.ascii = m_x ? 8'h00 : ((m_lsh || m_rsh) ? hi_tab[b] : lo_tab[b]);
        exp_q.push_back(e);
        if (make) begin
          m_cnt = m_cnt + 8'd1; m_hcode = b; m_hext = m_x; m_hvld = 1;
        end else if (same) begin
          m_hvld = 0;
        end
        if (!m_x && b == 8'h12) m_lsh = make;
        if (!m_x && b == 8'h59) m_rsh = make;
      end
      m_x = 0; m_b = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input ev_t e);
    return {14'd0, e.code, e.ext, e.brk, e.ascii};
  endfunction

  // ---------------- per-cycle compare ----------------
  logic       pend_acc, pend_hs;
  logic [7:0] pend_byte;
  ev_t        cap, cur;

  initial begin
    pend_acc = 0; pend_hs = 0; pend_byte = 0;
    m_reset();
    forever begin
      @(negedge clk);
      cur = '{code: ev_code, ext: ev_ext, brk: ev_break, ascii: ev_ascii};
      if (!clrn) begin
        m_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_fields", pk(cur), 0);
        chk("rst_key_cnt", key_cnt, 0);
        chk("rst_shift_err", {shift, err}, 0);
      end else begin
        if (pend_hs) begin
          ev_log.push_back(cap);
          if (exp_q.size() != 0) exp_q.delete(0);
        end
        if (pend_acc) m_byte(pend_byte);
        chk("in_ready", in_ready, exp_q.size() == 0);
        chk("ev_valid", ev_valid, exp_q.size() != 0);
        if (ev_valid && exp_q.size() != 0) chk("ev_fields", pk(cur), pk(exp_q[0]));
        chk("key_cnt", key_cnt, m_cnt);
        chk("shift", shift, m_lsh | m_rsh);
        chk("err", err, m_err);
      end
      pend_acc  = clrn && in_valid && in_ready;
      pend_byte = in_data;
      pend_hs   = clrn && ev_valid && ev_ready;
      cap       = cur;
    end
  end

  initial begin
    ev1_n = 0;
    forever begin
      @(negedge clk);
      if (!clrn) ev1_n = 0;
      else if (ev_valid1 && ev_ready1) ev1_n++;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    ev_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ev_ready = ($urandom_range(0, 3) != 0);
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [7:0] b);
    int   n = 0;
    logic acc = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send1(input logic [7:0] b);
    int   n = 0;
    logic acc = 0;
    in_data1  = b;
    in_valid1 = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid1 = 1'b0;
    if (!acc) chk("send1_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int   n = 0;
    logic done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready && !ev_valid;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clrn = 1'b1;
    ev_log.delete();
  endtask

  task automatic chk_ev(input string name, input int i, input logic [7:0] code,
                        input logic ext, input logic brk, input logic [7:0] ascii);
    ev_t e;
    e = '{code: code, ext: ext, brk: brk, ascii: ascii};
    chk(name, (i < ev_log.size()) ? pk(ev_log[i]) : 32'hFFFF_FFFF, pk(e));
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 24) return 8'hF0;
    if (r < 26) return 8'hE1;
    if (r < 27) return 8'h00;
    if (r < 28) return 8'hFF;
    if (r < 36) return r[0] ? 8'h12 : 8'h59;
    if (r < 90) return pool[$urandom_range(0, 7)];
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    clrn = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_valid1 = 1'b0; in_data1 = 8'h00;
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    clrn = 1'b1;

    send(8'h1C); send(8'hF0); send(8'h1C); wait_idle();
    chk("a_events", ev_log.size(), 2);
    chk_ev("a_make", 0, 8'h1C, 0, 0, 8'h61);
    chk_ev("a_break", 1, 8'h1C, 0, 1, 8'h61);
    chk("a_key_cnt", key_cnt, 1);

    do_reset();
    send(8'h12); wait_idle();
    chk("sh_held", shift, 1);
    send(8'h1C); send(8'hF0); send(8'h1C); wait_idle();
    chk("sh_still", shift, 1);
    send(8'hF0); send(8'h12); wait_idle();
    chk("sh_released", shift, 0);
    chk_ev("sh_ev0", 0, 8'h12, 0, 0, 8'h00);
    chk_ev("sh_ev1", 1, 8'h1C, 0, 0, 8'h41);
    chk_ev("sh_ev2", 2, 8'h1C, 0, 1, 8'h41);
    chk_ev("sh_ev3", 3, 8'h12, 0, 1, 8'h00);
    chk("sh_key_cnt", key_cnt, 2);

    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); wait_idle();
    chk_ev("ext_make", 0, 8'h75, 1, 0, 8'h00);
    chk_ev("ext_break", 1, 8'h75, 1, 1, 8'h00);

    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); wait_idle();
    chk("rep0_events", ev_log.size(), 1);
    chk("rep0_key_cnt", key_cnt, 1);
    send1(8'h1C); send1(8'h1C); send1(8'h1C);
    repeat (3) @(posedge clk);
    #1;
    chk("rep1_events", ev1_n, 3);
    chk("rep1_key_cnt", key_cnt1, 3);

    // Partial sequences and pending events must not survive reset.
    do_reset();
    send(8'hE0); do_reset(); send(8'h75); wait_idle();
    chk_ev("rst_after_e0", 0, 8'h75, 0, 0, 8'h00);
    send(8'hF0); do_reset(); send(8'h1C); wait_idle();
    chk_ev("rst_after_f0", 0, 8'h1C, 0, 0, 8'h61);
    rdy_mode = 2;
    send(8'h29); do_reset();
    @(negedge clk);
    chk("rst_in_out", ev_valid, 0);
    @(posedge clk);
    #1;
    rdy_mode = 1;

    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
    end
    wait_idle();
    chk("wrap_255", key_cnt, 255);
    send(8'h1C); send(8'hF0); send(8'h1C); wait_idle();
    chk("wrap_0", key_cnt, 0);

    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      send(rand_byte());
    end
    rdy_mode = 1;
    wait_idle();

    // Back-pressure: event held stable while bytes wait.
    do_reset();
    rdy_mode = 2;
    send(8'h1C);
    in_data  = 8'h29;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ev_valid", ev_valid, 1);
      chk("stall_ev", {14'd0, ev_code, ev_ext, ev_break, ev_ascii}, {14'd0, 8'h1C, 2'b00, 8'h61});
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    send(8'h29); wait_idle();
    send(8'hFF);
    @(negedge clk);
    chk("err_set", err, 1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("post_rst_err", err, 0);
    chk("post_rst_cnt", key_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter REPEAT_EN, default 0, meaning 1 = emit typematic repeat make events, 0 = suppress them.
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port clrn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 8, a set-2 scan byte from the PS/2 receiver FIFO.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data holds a byte.
REQ-006 SHALL have port in_ready, output, 1, meaning the decoder accepts in_data this cycle.
REQ-007 SHALL have port ev_valid, output, 1, meaning a key event is presented.
REQ-008 SHALL have port ev_ready, input, 1, meaning the consumer takes the event this cycle.
REQ-009 SHALL have port ev_code, output, 8, the event scan code without its prefix bytes.
REQ-010 SHALL have port ev_ext, output, 1, meaning the event was E0-prefixed.
REQ-011 SHALL have port ev_break, output, 1, meaning 1 = release, 0 = press.
REQ-012 SHALL have port ev_ascii, output, 8, the ASCII of the event, shift applied, 0 if none.
REQ-013 SHALL have port key_cnt, output, 8, the count of emitted press events.
REQ-014 SHALL have port shift, output, 1, meaning left or right shift is currently held.
REQ-015 SHALL have port err, output, 1, a sticky flag set when an 00 or FF byte is received.

Function
REQ-016 A byte SHALL be consumed only in a cycle where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in every state except OUT.
REQ-018 The FSM SHALL have exactly these states: IDLE, EXT, BRK, EXT_BRK, OUT.
REQ-019 Byte E0 SHALL move any non-OUT state to EXT.
REQ-020 Byte F0 SHALL move IDLE to BRK and EXT to EXT_BRK; BRK and EXT_BRK SHALL stay where they are.
REQ-021 Byte E1 SHALL be discarded with no state change.
REQ-022 Byte 00 or FF SHALL set err, discard the byte and return the FSM to IDLE.
REQ-023 Any other byte SHALL latch ev_code, set ev_ext=1 when in EXT/EXT_BRK, set ev_break=1 when in BRK/EXT_BRK, and go to OUT; the exception is suppression under REQ-025, which returns the FSM to IDLE.
REQ-024 The decoder SHALL hold a held-key register (code plus ext bit, with a valid bit); a make sets it, and a break matching the held key clears it.
REQ-025 When REPEAT_EN=0, a make equal to the held key while the valid bit is set SHALL be suppressed, with no event and no key_cnt change.
REQ-026 ev_valid SHALL assert the cycle after the final byte is accepted, a latency of 1 clock.
REQ-027 ev_valid and all ev_* outputs SHALL stay stable until ev_valid and ev_ready are both 1 in the same cycle; the FSM then goes to IDLE in the next cycle.
REQ-028 There SHALL be no byte acceptance in the same cycle as an event handoff.
REQ-029 key_cnt SHALL increment by 1 when a press event is latched into OUT, and SHALL wrap from 255 to 0.
REQ-030 A non-extended 12 or 59 make SHALL set the corresponding shift bit, and its break SHALL clear that bit.
REQ-031 Shift SHALL update when the event is latched, so a shift event's own ev_ascii is 0.
REQ-032 ev_ascii SHALL be the table output for a non-extended code with shift applied; letters SHALL map to uppercase when shift=1 and lowercase otherwise.
REQ-033 ev_ascii SHALL be 0 for extended codes and for unmapped codes.
REQ-034 ev_ascii SHALL be valid for both press and release events.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 While clrn=0, the FSM SHALL be IDLE and in_ready=1.
REQ-037 While clrn=0, ev_valid, ev_code, ev_ext, ev_break, ev_ascii, key_cnt, shift and err SHALL all be 0, and the held key SHALL be invalid.
REQ-038 A reset asserted mid-sequence (after E0 or F0, or in OUT) SHALL drop the partial sequence or pending event.
REQ-039 The first byte accepted after reset SHALL be decoded from IDLE.

Structure
REQ-040 A shared package SHALL hold the state enum and the constants PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, ERR_00=00 and ERR_FF=FF.
REQ-041 There SHALL be one sub-module, scancode_ascii: combinational, with inputs code[7:0] and shift and output ascii[7:0], covering letters, digits, space, enter and basic punctuation.

Verification
REQ-042 Bytes 1C, F0, 1C with ev_ready=1 -> events {1C, ext0, brk0, ascii 61} then {1C, ext0, brk1, ascii 61}; key_cnt=1.
REQ-043 Bytes 12, 1C, F0 1C, F0 12 -> events with ascii 0, 41, 41, 0; shift=1 between the events of 12 and F0 12; key_cnt=2.
REQ-044 Bytes E0, 75, E0, F0, 75 -> {75, ext1, brk0, ascii 0} then {75, ext1, brk1}.
REQ-045 Bytes 1C, 1C, 1C with REPEAT_EN=0 -> one event and key_cnt=1; with REPEAT_EN=1 -> three events and key_cnt=3.
REQ-046 Scenario: ev_ready=0 for 5 cycles with in_valid=1. Required response: in_ready=0 and ev_* stable throughout. Then byte FF followed by reset. Required response: err=1, then all outputs 0 after reset.
REQ-047 Scenario: 256 press/release pairs. Required response: key_cnt wraps to 0.
